// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control FSM (fetch/decode/memory/ALU/branch).
// Optional branch-with-link support is enabled by defining MC_CONTROLLER_BL_EN.
`default_nettype none

module mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl,
  output logic         LinkWrite,
  output logic         Illegal,
  output logic [3:0]   State
);

`ifdef MC_CONTROLLER_BL_EN
  localparam logic BL_EN = 1'b1;
`else
  localparam logic BL_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;
  logic       illegal_q, illegal_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  // Data-processing command decode
  logic       cmd_legal;
  logic       cmd_cmp;
  logic       cmd_arith;
  logic [1:0] cmd_alu;

  always_comb begin
    cmd_legal = 1'b1;
    cmd_cmp   = 1'b0;
    cmd_arith = 1'b0;
    cmd_alu   = 2'b00;
    case (funct[4:1])
      4'b0100: begin cmd_alu = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = 2'b01; cmd_arith = 1'b1; end
      4'b1010: begin cmd_alu = 2'b01; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
      4'b0000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      default: cmd_legal = 1'b0;
    endcase
  end

  // Condition check against the stored NZCV
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  logic is_execute;
  assign is_execute = (state_q == EXECUTER) || (state_q == EXECUTEI);

  always_comb begin
    flags_d = flags_q;
    if (is_execute && cond_ok_q && cmd_legal && (funct[0] || cmd_cmp)) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cmd_arith) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
    cond_ok_d = (state_q == DECODE) ? cond_pass : cond_ok_q;
    // Raised on leaving DECODE so the flag is already visible in UNKNOWN/EXECUTE
    illegal_d = illegal_q ||
                ((state_q == DECODE) &&
                 ((op == 2'b11) || ((op == 2'b00) && !cmd_legal)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
      illegal_q <= illegal_d;
    end
  end

  logic pcw_raw, mw_raw, rgw_raw, irw_raw, lnk_raw;

  always_comb begin
    pcw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rgw_raw    = 1'b0;
    irw_raw    = 1'b0;
    lnk_raw    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mw_raw = cond_ok_q;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        if (cond_ok_q) begin
          pcw_raw = (rd == 4'd15);
          rgw_raw = (rd != 4'd15);
        end
      end
      EXECUTER: begin
        ALUControl = cmd_alu;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd_alu;
      end
      ALUWB: begin
        // Compares and undecodable commands never commit a result
        if (cond_ok_q && cmd_legal && !cmd_cmp) begin
          pcw_raw = (rd == 4'd15);
          rgw_raw = (rd != 4'd15);
        end
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_raw   = cond_ok_q;
        if (BL_EN && cond_ok_q && funct[4]) begin
          rgw_raw = 1'b1;
          lnk_raw = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCWrite   = reset && pcw_raw;
  assign MemWrite  = reset && mw_raw;
  assign RegWrite  = reset && rgw_raw;
  assign IRWrite   = reset && irw_raw;
  assign LinkWrite = reset && lnk_raw;

  assign ImmSrc  = (op == 2'b11) ? 2'b00 : op;
  assign RegSrc  = {(op == 2'b01) && !funct[0], (op == 2'b10)};
  assign Illegal = illegal_q;
  assign State   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench for mc_controller (default build).
`default_nettype none

module tb_mc_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:12] Instr = '0;
  logic [3:0]   ALUFlags = '0;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, LinkWrite, Illegal;
  logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]   State;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .LinkWrite(LinkWrite), .Illegal(Illegal), .State(State)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [3:0] m_nzcv = 4'b0000;
  bit         m_illegal = 1'b0;
  logic [7:0] g_pcw_mask, g_rgw_mask, g_mw_mask, g_irw_mask;

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // -1 marks an undecodable data-processing command
  function automatic int alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b1010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int path_len(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      default: return 3;
    endcase
  endfunction

  function automatic int path_state(input logic [19:0] ins, input int i);
    int seq_dp [4]  = '{0, 1, 6, 8};
    int seq_ldr [5] = '{0, 1, 2, 3, 4};
    int seq_str [4] = '{0, 1, 2, 5};
    if (i < 2) return i;
    case (ins[15:14])
      2'b00:   return (i == 2) ? (ins[13] ? 7 : 6) : seq_dp[i];
      2'b01:   return ins[8] ? seq_ldr[i] : seq_str[i];
      2'b10:   return 9;
      default: return 10;
    endcase
  endfunction

  function automatic logic [22:0] expect_vec(input int s, input logic [19:0] ins,
                                             input bit ok, input bit ill);
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    int         code;
    logic       pcw, mw, rgw, irw, adr, lnk;
    logic [1:0] rs, sa, sb, res, imm, alu;
    op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0];
    code = alu_code(fn[4:1]);
    {pcw, mw, rgw, irw, adr, lnk} = '0;
    {sa, sb, res, alu} = '0;
    imm = (op == 2'b11) ? 2'b00 : op;
    rs  = {op == 2'b01 && !fn[0], op == 2'b10};
    case (s)
      0: begin pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
      1: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
      2: sb = 2'b01;
      3: adr = 1;
      4: begin res = 2'b01; if (ok) begin pcw = (rd == 15); rgw = (rd != 15); end end
      5: begin adr = 1; mw = ok; end
      6: alu = (code >= 0) ? 2'(code) : 2'b00;
      7: begin sb = 2'b01; alu = (code >= 0) ? 2'(code) : 2'b00; end
      8: if (ok && code >= 0 && fn[4:1] != 4'b1010) begin
           pcw = (rd == 15); rgw = (rd != 15);
         end
      9: begin sb = 2'b01; res = 2'b10; pcw = ok; end
      default: ;
    endcase
    return {4'(s), pcw, mw, rgw, irw, adr, lnk, ill, rs, sa, sb, res, imm, alu};
  endfunction

  task automatic model_reset();
    m_nzcv    = 4'b0000;
    m_illegal = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // Runs one instruction starting in FETCH; abort_at >= 0 asserts reset after that cycle
  task automatic run_instr(input logic [19:0] ins, input bit fix, input logic [3:0] ff,
                           input int abort_at);
    logic [22:0] exp_v, act_v;
    bit          ok, bad;
    int          s, code;
    logic [5:0]  fn;
    fn   = ins[13:8];
    code = alu_code(fn[4:1]);
    ok   = cond_holds(ins[19:16], m_nzcv);
    bad  = (ins[15:14] == 2'b11) || (ins[15:14] == 2'b00 && code < 0);
    Instr = ins;
    g_pcw_mask = '0; g_rgw_mask = '0; g_mw_mask = '0; g_irw_mask = '0;
    for (int i = 0; i < path_len(ins); i++) begin
      s = path_state(ins, i);
      ALUFlags = fix ? ff : 4'($urandom);
      @(negedge clk);
      exp_v = expect_vec(s, ins, ok, m_illegal);
      act_v = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, LinkWrite, Illegal,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs instr=%h cycle=%0d: got %h expected %h", ins, i, act_v, exp_v);
      end
      g_pcw_mask[i] = PCWrite; g_rgw_mask[i] = RegWrite;
      g_mw_mask[i]  = MemWrite; g_irw_mask[i] = IRWrite;
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        n_checks++;
        if ({State, PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite} !== 9'b0) begin
          n_fail++;
          $display("FAIL abort_immediate: got state=%0d pcw=%b mw=%b rgw=%b irw=%b expected all 0",
                   State, PCWrite, MemWrite, RegWrite, IRWrite);
        end
        return;
      end
      @(posedge clk);
      if ((s == 6 || s == 7) && ok && code >= 0 && (fn[0] || fn[4:1] == 4'b1010)) begin
        m_nzcv[3:2] = ALUFlags[3:2];
        if (fn[4:1] inside {4'b0100, 4'b0010, 4'b1010}) m_nzcv[1:0] = ALUFlags[1:0];
      end
      if (i == 1 && bad) m_illegal = 1'b1;
      #1;
    end
  endtask

  localparam logic [19:0] LDR_R1 = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h1};

  task automatic test_reset();
    Instr = LDR_R1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({State, PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite, Illegal} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got state=%0d pcw=%b mw=%b rgw=%b irw=%b lnk=%b ill=%b expected 0",
                 State, PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite, Illegal);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    run_instr(LDR_R1, 1'b0, 4'h0, -1);
    n_checks++;
    if (!(g_irw_mask[0] === 1'b1 && g_pcw_mask[0] === 1'b1)) begin
      n_fail++;
      $display("FAIL first_fetch: got irw=%b pcw=%b expected 1 1", g_irw_mask[0], g_pcw_mask[0]);
    end
  endtask

  task automatic test_ldr();
    run_instr(LDR_R1, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_rgw_mask !== 8'b0001_0000) begin
      n_fail++;
      $display("FAIL ldr_regwrite: got mask %b expected 00010000", g_rgw_mask);
    end
  endtask

  task automatic test_str_cond();
    run_instr({4'h0, 2'b01, 6'b011000, 4'h0, 4'h2}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_mw_mask !== 8'b0) begin
      n_fail++;
      $display("FAIL streq_memwrite: got mask %b expected 00000000", g_mw_mask);
    end
    run_instr({4'hE, 2'b01, 6'b011000, 4'h0, 4'h2}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_mw_mask !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL stral_memwrite: got mask %b expected 00001000", g_mw_mask);
    end
  endtask

  task automatic test_flags_branch();
    run_instr({4'hE, 2'b00, 6'b000101, 4'h1, 4'h3}, 1'b1, 4'b0100, -1);
    run_instr({4'h0, 2'b10, 6'b000000, 4'h0, 4'h0}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_pcw_mask !== 8'b0000_0101) begin
      n_fail++;
      $display("FAIL beq_taken: got pcw mask %b expected 00000101", g_pcw_mask);
    end
    run_instr({4'h1, 2'b10, 6'b010000, 4'h0, 4'h0}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_pcw_mask !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL bne_not_taken: got pcw mask %b expected 00000001", g_pcw_mask);
    end
  endtask

  task automatic test_random();
    logic [3:0]  cmds [5] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100};
    logic [19:0] ins;
    for (int k = 0; k < 80; k++) begin
      ins = 20'($urandom);
      ins[15:14] = 2'($urandom_range(0, 2));
      if (ins[15:14] == 2'b00) ins[12:9] = cmds[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
      run_instr(ins, 1'b0, 4'h0, -1);
    end
  endtask

  task automatic test_illegal();
    do_reset(2);
    run_instr({4'hE, 2'b11, 6'($urandom), 4'h0, 4'h0}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_pcw_mask !== 8'b1 || g_rgw_mask !== 8'b0 || g_mw_mask !== 8'b0) begin
      n_fail++;
      $display("FAIL undef_writes: got pcw=%b rgw=%b mw=%b expected 00000001 0 0",
               g_pcw_mask, g_rgw_mask, g_mw_mask);
    end
    run_instr({4'hE, 2'b00, 6'b001000, 4'h1, 4'h2}, 1'b0, 4'h0, -1);
    n_checks++;
    if (Illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sticky: got %b expected 1", Illegal);
    end
    do_reset(2);
    run_instr({4'hE, 2'b00, 6'b000011, 4'h1, 4'h4}, 1'b1, 4'b0100, -1);
    n_checks++;
    if (g_rgw_mask !== 8'b0 || Illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_cmd: got rgw mask %b illegal %b expected 0 1", g_rgw_mask, Illegal);
    end
    run_instr({4'h0, 2'b10, 6'b000000, 4'h0, 4'h0}, 1'b0, 4'h0, -1);
    n_checks++;
    if (g_pcw_mask !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL bad_cmd_flags: got pcw mask %b expected 00000001", g_pcw_mask);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    run_instr({4'hE, 2'b01, 6'b011000, 4'h0, 4'h5}, 1'b0, 4'h0, 3);
    @(negedge clk);
    n_checks++;
    if ({State, PCWrite, MemWrite, RegWrite, IRWrite, Illegal} !== 9'b0) begin
      n_fail++;
      $display("FAIL abort_hold: got state=%0d pcw=%b mw=%b rgw=%b irw=%b expected 0",
               State, PCWrite, MemWrite, RegWrite, IRWrite);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    run_instr({4'hE, 2'b00, 6'b101001, 4'h0, 4'h6}, 1'b0, 4'h0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldr();
    test_str_cond();
    test_flags_branch();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
